// File: rtl/ddr3_rd_control.sv
// DDR3 read controller: walks one fill descriptor at a time, issues credit-limited
// burst reads for the whole fill and forwards the returned words in order.
module ddr3_rd_control #(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_enabled,
  input  logic [127:0] fill_header_rd_dat,
  input  logic         fill_header_empty,
  output logic         fill_header_rd_en,
  output logic [25:0]  ddr3_rd_addr,
  output logic         rd_app_en,
  input  logic         rd_app_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic [127:0] ddr3_rd_fifo_dat,
  output logic         ddr3_rd_fifo_wr_en,
  input  logic         ddr3_rd_fifo_prog_full,
  output logic         ddr3_rd_busy,
  output logic         ddr3_rd_sync_err,
  output logic         ddr3_rd_hdr_err,
  output logic         ddr3_rd_done
);

  localparam int         DATA_W  = 128;
  localparam logic [4:0] MAX_OUT = 5'(MAX_OUTSTANDING);

  typedef enum logic [7:0] {
    IDLE        = 8'b0000_0001,
    TST_HDR_TAG = 8'b0000_0010,
    SYNC_ERR    = 8'b0000_0100,
    INIT        = 8'b0000_1000,
    ADJ_CNT     = 8'b0001_0000,
    READ        = 8'b0010_0000,
    DRAIN       = 8'b0100_0000,
    DONE        = 8'b1000_0000
  } state_t;

  function automatic logic tag_ok(input logic [DATA_W-1:0] d);
    return d[127:126] == 2'b01;
  endfunction

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   desc;
  logic [22:0]         addr_gen;
  logic [20:0]         addr_cntr, addr_cntr_nxt;
  logic [20:0]         ret_cntr, ret_cntr_nxt;
  logic [4:0]          outstanding;
  logic                first_pend;
  logic                sync_err_q, hdr_err_q;
  logic                active, ret_vld, out_dec, cmd_acc;
  logic                fifo_vld_p1;
  logic [DATA_W-1:0]   fifo_dat_p1;

  assign active  = (state == READ) || (state == DRAIN);
  assign ret_vld = app_rd_data_valid && active;
  assign out_dec = ret_vld && (outstanding != 5'd0);

  assign rd_app_en = (state == READ) && (addr_cntr != 21'd0) &&
                     (outstanding < MAX_OUT) && !ddr3_rd_fifo_prog_full;
  assign cmd_acc   = rd_app_en && rd_app_rdy;

  assign addr_cntr_nxt = cmd_acc ? addr_cntr - 21'd1 : addr_cntr;
  assign ret_cntr_nxt  = (ret_vld && ret_cntr != 21'd0) ? ret_cntr - 21'd1 : ret_cntr;

  assign fill_header_rd_en  = (state == INIT);
  assign ddr3_rd_addr       = {addr_gen, 3'b000};
  assign ddr3_rd_busy       = (state != IDLE);
  assign ddr3_rd_done       = (state == DONE);
  assign ddr3_rd_sync_err   = sync_err_q;
  assign ddr3_rd_hdr_err    = hdr_err_q;
  assign ddr3_rd_fifo_wr_en = fifo_vld_p1;
  assign ddr3_rd_fifo_dat   = fifo_dat_p1;

  // Look ahead on the counters so DONE follows the last return by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (!fill_header_empty) state_nxt = TST_HDR_TAG;
      TST_HDR_TAG: state_nxt = tag_ok(fill_header_rd_dat) ? INIT : SYNC_ERR;
      SYNC_ERR:    state_nxt = SYNC_ERR;
      INIT:        state_nxt = ADJ_CNT;
      ADJ_CNT:     state_nxt = READ;
      READ:        if (addr_cntr_nxt == 21'd0)
                     state_nxt = (ret_cntr_nxt == 21'd0) ? DONE : DRAIN;
      DRAIN:       if (ret_cntr_nxt == 21'd0) state_nxt = DONE;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
    if (!rd_enabled) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (state == TST_HDR_TAG) desc <= fill_header_rd_dat;
  end

  // p0 -> p1: returned word registered into the readout FIFO write port.
  always_ff @(posedge clk) begin
    if (reset || !rd_enabled) begin
      state       <= IDLE;
      addr_gen    <= '0;
      addr_cntr   <= '0;
      ret_cntr    <= '0;
      outstanding <= '0;
      first_pend  <= 1'b0;
      fifo_vld_p1 <= 1'b0;
      if (reset) begin
        sync_err_q  <= 1'b0;
        hdr_err_q   <= 1'b0;
        fifo_dat_p1 <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        TST_HDR_TAG: if (!tag_ok(fill_header_rd_dat)) sync_err_q <= 1'b1;
        INIT: begin
          addr_gen   <= desc[57:35];
          addr_cntr  <= desc[84:64];
          ret_cntr   <= desc[84:64];
          first_pend <= 1'b1;
        end
        ADJ_CNT: begin
          addr_cntr <= addr_cntr + 21'd2;
          ret_cntr  <= ret_cntr + 21'd2;
        end
        default: begin
          if (cmd_acc) addr_gen <= addr_gen + 23'd1;
          addr_cntr <= addr_cntr_nxt;
          ret_cntr  <= ret_cntr_nxt;
        end
      endcase

      if (cmd_acc && !out_dec)      outstanding <= outstanding + 5'd1;
      else if (!cmd_acc && out_dec) outstanding <= outstanding - 5'd1;

      fifo_vld_p1 <= ret_vld;
      if (ret_vld) begin
        fifo_dat_p1 <= app_rd_data;
        first_pend  <= 1'b0;
        if (first_pend && app_rd_data != desc) hdr_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_rd_control.sv
// Bench for ddr3_rd_control: a queue-based memory responder and readout model
// predict the address stream and forwarded data of every fill.
`timescale 1ns/1ps
module tb_ddr3_rd_control;

  logic         clk = 1'b0;
  logic         reset, rd_enabled;
  logic [127:0] fill_header_rd_dat;
  logic         fill_header_empty, fill_header_rd_en;
  logic [25:0]  ddr3_rd_addr;
  logic         rd_app_en, rd_app_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic [127:0] ddr3_rd_fifo_dat;
  logic         ddr3_rd_fifo_wr_en, ddr3_rd_fifo_prog_full;
  logic         ddr3_rd_busy, ddr3_rd_sync_err, ddr3_rd_hdr_err, ddr3_rd_done;

  always #5 clk = ~clk;

  ddr3_rd_control #(.MAX_OUTSTANDING(16)) dut (
    .clk(clk), .reset(reset), .rd_enabled(rd_enabled),
    .fill_header_rd_dat(fill_header_rd_dat), .fill_header_empty(fill_header_empty),
    .fill_header_rd_en(fill_header_rd_en), .ddr3_rd_addr(ddr3_rd_addr),
    .rd_app_en(rd_app_en), .rd_app_rdy(rd_app_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .ddr3_rd_fifo_dat(ddr3_rd_fifo_dat), .ddr3_rd_fifo_wr_en(ddr3_rd_fifo_wr_en),
    .ddr3_rd_fifo_prog_full(ddr3_rd_fifo_prog_full), .ddr3_rd_busy(ddr3_rd_busy),
    .ddr3_rd_sync_err(ddr3_rd_sync_err), .ddr3_rd_hdr_err(ddr3_rd_hdr_err),
    .ddr3_rd_done(ddr3_rd_done)
  );

  typedef struct { logic [22:0] a; int due; } req_t;

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  int lat = 3;
  bit hold_mode = 1'b0;
  int rel_limit = 0, n_returned = 0;
  int unsigned rdy_pct = 100;
  int pf_start = -1, pf_end = -1;
  int pop_cnt = 0, done_cnt = 0, throttle_viol = 0;
  int pop_base = 0, done_base = 0;
  int done_cyc = 0, last_vld_cyc = 0;
  req_t         pend_q[$];
  logic [25:0]  issued_q[$];
  logic [127:0] fifo_q[$];
  logic [127:0] hdr_mem[int];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: descriptors stored at fill starts, a hash elsewhere.
  function automatic logic [127:0] mem_word(input logic [22:0] a);
    logic [31:0] w;
    if (hdr_mem.exists(int'(a))) return hdr_mem[int'(a)];
    w = {9'h0, a} * 32'h9E37_79B1;
    return {w, ~w, w ^ 32'h5A5A_5A5A, {9'h0, a}};
  endfunction

  function automatic logic [127:0] mk_desc(input logic [1:0] tag, input logic [22:0] st,
                                           input logic [20:0] bc);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[127:126] = tag;
    d[84:64]   = bc;
    d[57:35]   = st;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: record commands, FIFO writes, pops and done pulses mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_app_en && rd_app_rdy) begin
        issued_q.push_back(ddr3_rd_addr);
        pend_q.push_back('{a: ddr3_rd_addr[25:3], due: cyc + lat});
      end
      if (rd_app_en && ddr3_rd_fifo_prog_full) throttle_viol++;
      if (ddr3_rd_fifo_wr_en) fifo_q.push_back(ddr3_rd_fifo_dat);
      if (fill_header_rd_en) pop_cnt++;
      if (ddr3_rd_done) begin done_cnt++; done_cyc = cyc; end
      if (app_rd_data_valid) last_vld_cyc = cyc;
    end
  end

  // Memory responder: in-order returns after lat cycles, optionally withheld.
  initial begin
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      app_rd_data_valid = 1'b0;
      if (pend_q.size() > 0 && (!hold_mode || n_returned < rel_limit)) begin
        if (pend_q[0].due <= cyc) begin
          app_rd_data_valid = 1'b1;
          app_rd_data = mem_word(pend_q[0].a);
          void'(pend_q.pop_front());
          n_returned++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive_step();
    rd_app_rdy = ($urandom_range(0, 99) < rdy_pct);
    ddr3_rd_fifo_prog_full = (cyc >= pf_start) && (cyc < pf_end);
    if (pop_cnt != pop_base) fill_header_empty = 1'b1;
  endtask

  task automatic drive_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      drive_step();
    end
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk); #1;
      drive_step();
      got = (done_cnt != done_base);
    end
    chk("done_seen", 128'(got), 128'(1));
  endtask

  task automatic present(input logic [127:0] d);
    issued_q.delete();
    fifo_q.delete();
    pop_base  = pop_cnt;
    done_base = done_cnt;
    @(posedge clk); #1;
    fill_header_rd_dat = d;
    fill_header_empty  = 1'b0;
  endtask

  // Expected fill: burst_cnt+2 (21-bit) consecutive addresses, wrapping at 2^23.
  task automatic check_fill(input string tag, input logic [22:0] st, input logic [20:0] bc);
    logic [20:0] tot;
    int n, bad_a, bad_d;
    logic [22:0] a;
    tot = bc + 21'd2;
    n = int'(tot);
    bad_a = -1;
    bad_d = -1;
    chk({tag, "_nreads"}, 128'(issued_q.size()), 128'(n));
    chk({tag, "_nwrites"}, 128'(fifo_q.size()), 128'(n));
    for (int i = 0; i < n; i++) begin
      a = st + 23'(i);
      if (bad_a < 0 && i < issued_q.size() && issued_q[i] !== {a, 3'b000}) bad_a = i;
      if (bad_d < 0 && i < fifo_q.size() && fifo_q[i] !== mem_word(a)) bad_d = i;
    end
    chk({tag, "_addr_first_bad_idx"}, 128'(bad_a), 128'(-1));
    chk({tag, "_data_first_bad_idx"}, 128'(bad_d), 128'(-1));
    chk({tag, "_pops"}, 128'(pop_cnt - pop_base), 128'(1));
    chk({tag, "_dones"}, 128'(done_cnt - done_base), 128'(1));
    chk({tag, "_done_lat"}, 128'(done_cyc - last_vld_cyc), 128'(1));
  endtask

  task automatic run_fill(input string tag, input logic [22:0] st, input logic [20:0] bc,
                          input int budget);
    logic [127:0] d;
    d = mk_desc(2'b01, st, bc);
    hdr_mem[int'(st)] = d;
    present(d);
    wait_done(budget);
    check_fill(tag, st, bc);
    chk({tag, "_hdr_err"}, 128'(ddr3_rd_hdr_err), 128'(0));
  endtask

  initial begin
    logic [127:0] d;
    logic [22:0]  st;
    logic [20:0]  bc;
    int           w0;
    bit           got;

    reset = 1'b1;
    rd_enabled = 1'b1;
    fill_header_rd_dat = '0;
    fill_header_empty = 1'b1;
    rd_app_rdy = 1'b1;
    ddr3_rd_fifo_prog_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 128'(fill_header_rd_en), 128'(0));
    chk("rst_app_en", 128'(rd_app_en), 128'(0));
    chk("rst_addr", 128'(ddr3_rd_addr), 128'(0));
    chk("rst_wr_en", 128'(ddr3_rd_fifo_wr_en), 128'(0));
    chk("rst_fifo_dat", ddr3_rd_fifo_dat, 128'(0));
    chk("rst_busy", 128'(ddr3_rd_busy), 128'(0));
    chk("rst_sync_err", 128'(ddr3_rd_sync_err), 128'(0));
    chk("rst_hdr_err", 128'(ddr3_rd_hdr_err), 128'(0));
    chk("rst_done", 128'(ddr3_rd_done), 128'(0));
    reset = 1'b0;

    // Basic fill with start-up timing checks.
    d = mk_desc(2'b01, 23'h000010, 21'd0);
    hdr_mem[int'(23'h000010)] = d;
    present(d);
    @(negedge clk); chk("start_idle_busy", 128'(ddr3_rd_busy), 128'(0));
    @(negedge clk); chk("start_tst_busy", 128'(ddr3_rd_busy), 128'(1));
    @(negedge clk); chk("start_init_pop", 128'(fill_header_rd_en), 128'(1));
    @(negedge clk); chk("start_adj_no_cmd", 128'(rd_app_en), 128'(0));
    @(negedge clk); chk("start_first_cmd", 128'(rd_app_en), 128'(1));
    chk("start_first_addr", 128'(ddr3_rd_addr), 128'(26'h0000080));
    wait_done(60);
    check_fill("basic", 23'h000010, 21'd0);

    // Address wrap.
    run_fill("wrap", 23'h7FFFFF, 21'd1, 60);

    // Random fills with random latency and handshake rate.
    for (int i = 0; i < 4; i++) begin
      lat = $urandom_range(1, 6);
      rdy_pct = $urandom_range(30, 100);
      st = (i == 1) ? 23'h7FFFF8 : 23'($urandom);
      bc = 21'($urandom_range(0, 25));
      run_fill("rand", st, bc, 400);
    end

    // Throttle: 50% ready, prog_full high for 20 cycles mid-fill.
    lat = 3;
    rdy_pct = 50;
    pf_start = cyc + 15;
    pf_end = pf_start + 20;
    run_fill("throttle", 23'($urandom), 21'd70, 800);
    chk("throttle_no_cmd_when_full", 128'(throttle_viol), 128'(0));
    pf_start = -1;
    pf_end = -1;

    // Credit limit with returns withheld, then released one at a time.
    lat = 1;
    rdy_pct = 100;
    hold_mode = 1'b1;
    rel_limit = n_returned;
    st = 23'($urandom);
    d = mk_desc(2'b01, st, 21'd40);
    hdr_mem[int'(st)] = d;
    present(d);
    drive_cycles(40);
    chk("credit_issued_16", 128'(issued_q.size()), 128'(16));
    @(negedge clk); chk("credit_app_en_low", 128'(rd_app_en), 128'(0));
    rel_limit = n_returned + 1;
    drive_cycles(6);
    chk("credit_issued_17", 128'(issued_q.size()), 128'(17));
    rel_limit = n_returned + 1;
    drive_cycles(6);
    chk("credit_issued_18", 128'(issued_q.size()), 128'(18));
    hold_mode = 1'b0;
    wait_done(300);
    check_fill("credit", st, 21'd40);

    // Bad tag: sticky sync error, no pop, no commands; disable keeps it, reset clears it.
    lat = 3;
    d = mk_desc(2'b10, 23'h000100, 21'd3);
    present(d);
    drive_cycles(10);
    @(negedge clk);
    chk("sync_err_set", 128'(ddr3_rd_sync_err), 128'(1));
    chk("sync_busy", 128'(ddr3_rd_busy), 128'(1));
    chk("sync_no_cmd", 128'(issued_q.size()), 128'(0));
    chk("sync_no_pop", 128'(pop_cnt - pop_base), 128'(0));
    drive_cycles(10);
    chk("sync_err_sticky", 128'(ddr3_rd_sync_err), 128'(1));
    fill_header_empty = 1'b1;
    rd_enabled = 1'b0;
    @(posedge clk); #1;
    chk("disable_idle", 128'(ddr3_rd_busy), 128'(0));
    chk("disable_keeps_sync", 128'(ddr3_rd_sync_err), 128'(1));
    rd_enabled = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_clears_sync", 128'(ddr3_rd_sync_err), 128'(0));
    reset = 1'b0;

    // Header mismatch, then reset while reads are in flight.
    st = 23'($urandom);
    d = mk_desc(2'b01, st, 21'd100);
    hdr_mem[int'(st)] = d ^ 128'h1;
    present(d);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      drive_step();
      got = (fifo_q.size() > 0);
    end
    chk("hdr_first_write_seen", 128'(got), 128'(1));
    chk("hdr_err_set", 128'(ddr3_rd_hdr_err), 128'(1));
    if (fifo_q.size() > 0) chk("hdr_word_forwarded", fifo_q[0], d ^ 128'h1);
    drive_cycles(5);
    chk("mid_fill_busy", 128'(ddr3_rd_busy), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    w0 = fifo_q.size();
    chk("midrst_busy", 128'(ddr3_rd_busy), 128'(0));
    chk("midrst_app_en", 128'(rd_app_en), 128'(0));
    chk("midrst_wr_en", 128'(ddr3_rd_fifo_wr_en), 128'(0));
    chk("midrst_hdr_err", 128'(ddr3_rd_hdr_err), 128'(0));
    reset = 1'b0;
    drive_cycles(12);
    chk("late_valid_no_write", 128'(fifo_q.size()), 128'(w0));
    chk("late_valid_idle", 128'(ddr3_rd_busy), 128'(0));
    pend_q.delete();
    hdr_mem.delete(int'(st));

    // Normal operation resumes after the mid-fill reset.
    run_fill("post_reset", 23'h000200, 21'd5, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_rd_control.md
# ddr3_rd_control

Read-side counterpart of the DDR3 write controller. Takes one fill descriptor at a time from the fill-header FIFO and issues read commands to the DDR3 address controller for every burst of that fill, header and checksum included. Forwards returned read data, in order, into the readout FIFO. Outstanding reads are credit-limited so the readout FIFO can never overflow.

## Interface
Parameters:
- MAX_OUTSTANDING, 16: maximum issued-but-unreturned read bursts; range 1..31.

Ports:
- clk  in  1  DDR3-domain user clock.
- reset  in  1  synchronous, active-high reset.
- rd_enabled  in  1  readout enable; low forces IDLE, like reset, except sticky error flags are kept.
- fill_header_rd_dat  in  128  fill-header FIFO head (first-word fall-through).
- fill_header_empty  in  1  fill-header FIFO empty.
- fill_header_rd_en  out  1  pop fill-header FIFO.
- ddr3_rd_addr  out  26  read address, {addr_gen[22:0],3'b0}.
- rd_app_en  out  1  read command request.
- rd_app_rdy  in  1  command accepted when high together with rd_app_en.
- app_rd_data  in  128  returned read data.
- app_rd_data_valid  in  1  app_rd_data valid this cycle.
- ddr3_rd_fifo_dat  out  128  data to readout FIFO.
- ddr3_rd_fifo_wr_en  out  1  readout FIFO write strobe.
- ddr3_rd_fifo_prog_full  in  1  readout FIFO has fewer than MAX_OUTSTANDING+2 free entries.
- ddr3_rd_busy  out  1  high whenever not IDLE.
- ddr3_rd_sync_err  out  1  bad header tag; sticky.
- ddr3_rd_hdr_err  out  1  first returned word differs from descriptor; sticky until reset.
- ddr3_rd_done  out  1  one-cycle pulse at end of fill.

## Operation
Descriptor fields:
- [127:126] tag, must be 2'b01.
- [57:35] start address, 23 bits.
- [84:64] burst_cnt, 21 bits.
- Total bursts per fill = burst_cnt+2, computed in 21-bit arithmetic.

State machine, one-hot:
- IDLE: go to TST_HDR_TAG when !fill_header_empty.
- TST_HDR_TAG: latch descriptor. Tag 2'b01 → INIT; any other tag → SYNC_ERR.
- SYNC_ERR: terminal until reset or rd_enabled low. ddr3_rd_sync_err=1. FIFO is not popped.
- INIT: pulse fill_header_rd_en for exactly 1 cycle. Load addr_gen=start, addr_cntr=burst_cnt, ret_cntr=burst_cnt.
- ADJ_CNT: addr_cntr+=2, ret_cntr+=2. Next state READ.
- READ:
  - rd_app_en = CS[READ] && addr_cntr!=0 && outstanding<MAX_OUTSTANDING && !ddr3_rd_fifo_prog_full.
  - On command accept: addr_gen+1 (wraps modulo 2^23: 0x7FFFFF→0), addr_cntr-1.
  - When addr_cntr reaches 0 → DRAIN.
- DRAIN: no commands issued. When ret_cntr==0 → DONE.
- DONE: ddr3_rd_done=1 for 1 cycle, then IDLE.

Counters:
- outstanding (5 bits): +1 on accept only, -1 on valid only, hold when both or neither.
- ret_cntr: decrements on each app_rd_data_valid in READ or DRAIN.

Data handling:
- Every valid word in READ/DRAIN is written to the readout FIFO; no reordering.
- The first returned word of a fill is compared (all 128 bits) with the latched descriptor. Mismatch sets ddr3_rd_hdr_err; the word is still forwarded.
- app_rd_data_valid outside READ/DRAIN is discarded (stale returns after reset or disable).

Reset / rd_enabled low mid-fill:
- State → IDLE; all counters → 0.
- No FIFO pops or writes on the following cycle.

## Timing
- Reset values: fill_header_rd_en=0, rd_app_en=0, ddr3_rd_addr=0, ddr3_rd_fifo_wr_en=0, ddr3_rd_fifo_dat=0, ddr3_rd_busy=0, ddr3_rd_sync_err=0, ddr3_rd_hdr_err=0, ddr3_rd_done=0.
- rd_app_en and ddr3_rd_addr are combinational from registered state. rd_app_en is held until accepted or until a throttle condition drops it.
- Read data path has 1-cycle latency: ddr3_rd_fifo_wr_en/dat are registered copies of app_rd_data_valid/app_rd_data.
- From fill_header_empty falling in IDLE, the first rd_app_en occurs 4 cycles later: TST_HDR_TAG, INIT, ADJ_CNT, then READ.
- ddr3_rd_done fires 1 cycle after the last return is counted.
- With continuous rdy and immediate returns, sustained throughput is 1 burst/cycle.
- prog_full throttles only new commands. In-flight returns are always accepted, which is why the prog_full threshold has MAX_OUTSTANDING+2 margin.
- A fill with burst_cnt=0 still issues exactly 2 reads.

## Test plan
- Basic fill: descriptor tag 01, start 0x000010, burst_cnt 0; memory returns after 3 cycles → reads at 0x0000080 and 0x0000088, 2 FIFO writes, one done pulse, fill_header_rd_en exactly once.
- Bad tag 2'b10 → sync_err=1 and stays 1, no rd_app_en, no FIFO pop; reset clears it.
- Wrap: start 0x7FFFFF, burst_cnt 1 → addresses 0x3FFFFF8, 0x0000000, 0x0000008, then done.
- Credit limit: burst_cnt 40, rdy always 1, returns withheld → exactly 16 accepted commands, then rd_app_en=0. Each release of one return allows exactly one more command. All 42 words are forwarded in order.
- Throttle and handshake: random rd_app_rdy at 50%; prog_full held high for 20 cycles mid-fill → no command while prog_full is high, address sequence is gapless, total reads = burst_cnt+2.
- Header mismatch and reset mid-fill: first returned word ≠ descriptor → hdr_err=1 and data still forwarded. Reset asserted in READ → next cycle IDLE, busy=0, late valids produce no FIFO writes.
